// File: rtl/hex_scan_ctrl_pkg.sv
// Shared types and helpers for the hex display scan controller.
package hex_scan_ctrl_pkg;

  // Scan phase: dark blanking gap, or one digit position shown.
  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } scan_state_e;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hex_scan_ctrl_scan_timer.sv
// Loadable down-counter with a zero flag. Holds at zero until reloaded.
module scan_timer #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Reload takes priority; otherwise count down and park at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed scan controller for a shared 7-segment decoder.
// Alternates a dark GAP with a SHOW slot per digit, round-robin.
// Everything the display sees (nibble, enables, blank) is snapshotted
// at SHOW entry so mid-slot writes or input changes cannot tear a digit.
import hex_scan_ctrl_pkg::*;

module hex_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL_CYC  = 50000,
  parameter int GAP_CYC    = 500,
  parameter int AW         = clog2(NUM_DIGITS)
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  WrEn,
  input  logic [AW-1:0]         WrAddr,
  input  logic [3:0]            WrData,
  input  logic [NUM_DIGITS-1:0] BlankMask,
  input  logic                  LzEnable,
  output logic [3:0]            Nibble,
  output logic [NUM_DIGITS-1:0] DigitEn_n,
  output logic                  Blank,
  output logic                  FrameTick,
  output scan_state_e           o_dbg_state
);

  localparam int TW_RAW = clog2(max2(DWELL_CYC, GAP_CYC));
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

  localparam logic [TW-1:0]         GAP_LOAD   = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0]         DWELL_LOAD = TW'(DWELL_CYC - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_DARK   = '1;
  localparam logic [AW-1:0]         LAST_IDX   = AW'(NUM_DIGITS - 1);

  scan_state_e           r_state;
  scan_state_e           w_state_nxt;
  logic [AW-1:0]         r_index;
  logic [3:0]            r_digit     [NUM_DIGITS];
  logic [3:0]            w_digit_fwd [NUM_DIGITS];
  logic                  w_wr_ok;
  logic                  w_tmr_zero;
  logic                  w_load;
  logic [TW-1:0]         w_load_val;
  logic                  w_show_entry;
  logic                  w_show_exit;
  logic                  w_upper_nz;
  logic                  w_suppressed;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_en_lit;
  logic [3:0]            r_nibble;
  logic [NUM_DIGITS-1:0] r_digit_en_n;
  logic                  r_blank;
  logic                  r_frame_tick;

  assign w_wr_ok = WrEn && (int'(WrAddr) < NUM_DIGITS);

  // Reset is treated as a GAP entry, so the timer starts at the GAP load
  // value and the first SHOW comes exactly GAP_CYC cycles after release.
  scan_timer #(
    .W       (TW),
    .RST_VAL (GAP_LOAD)
  ) u_timer (
    .i_clk      (Clock),
    .i_rst_n    (Resetn),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_tmr_zero)
  );

  // Digit buffer; out-of-range addresses are dropped.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= 4'h0;
    end else if (w_wr_ok) begin
      r_digit[WrAddr] <= WrData;
    end
  end

  // Buffer view with this edge's write applied, so a write on the SHOW
  // entry edge is what gets displayed.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_digit_fwd[i] = r_digit[i];
      if (w_wr_ok && (int'(WrAddr) == i)) w_digit_fwd[i] = WrData;
    end
  end

  // Leading-zero suppression and lit decision for the upcoming digit.
  always_comb begin
    w_upper_nz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(r_index)) && (w_digit_fwd[i] != 4'h0)) w_upper_nz = 1'b1;
    end
    w_suppressed = LzEnable && (r_index != '0) && !w_upper_nz;
    w_lit        = !BlankMask[r_index] && !w_suppressed;
    w_en_lit          = ALL_DARK;
    w_en_lit[r_index] = 1'b0;
  end

  // Phase state register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_state <= ST_GAP;
    else         r_state <= w_state_nxt;
  end

  // Next phase and timer reload; every phase entry reloads the timer.
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_load_val   = GAP_LOAD;
    w_show_entry = 1'b0;
    w_show_exit  = 1'b0;
    case (r_state)
      ST_GAP: begin
        if (w_tmr_zero) begin
          w_state_nxt  = ST_SHOW;
          w_load       = 1'b1;
          w_load_val   = DWELL_LOAD;
          w_show_entry = 1'b1;
        end
      end
      ST_SHOW: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_GAP;
          w_load      = 1'b1;
          w_load_val  = GAP_LOAD;
          w_show_exit = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_GAP;
        w_load      = 1'b1;
        w_load_val  = GAP_LOAD;
      end
    endcase
  end

  // Display outputs: snapshot on SHOW entry, go dark and advance on exit.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_index      <= '0;
      r_nibble     <= 4'h0;
      r_digit_en_n <= ALL_DARK;
      r_blank      <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      if (w_show_entry) begin
        r_nibble     <= w_digit_fwd[r_index];
        r_digit_en_n <= w_lit ? w_en_lit : ALL_DARK;
        r_blank      <= !w_lit;
      end else if (w_show_exit) begin
        r_digit_en_n <= ALL_DARK;
        r_blank      <= 1'b1;
        if (r_index == LAST_IDX) begin
          r_index      <= '0;
          r_frame_tick <= 1'b1;
        end else begin
          r_index <= r_index + 1'b1;
        end
      end
    end
  end

  assign Nibble      = r_nibble;
  assign DigitEn_n   = r_digit_en_n;
  assign Blank       = r_blank;
  assign FrameTick   = r_frame_tick;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl: the reference derives every output from the
// number of clock edges since reset release using slot arithmetic, and a
// digit buffer mirror updated from the driven writes.
module tb_hex_scan_ctrl;
  import hex_scan_ctrl_pkg::*;

  localparam int ND    = 4;
  localparam int DW    = 4;
  localparam int GP    = 2;
  localparam int AW    = 2;
  localparam int SLOT  = DW + GP;
  localparam int FRAME = SLOT * ND;
  localparam int EW    = 4 + ND + 1 + 1 + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          Clock = 1'b0;
  logic          Resetn;
  logic          WrEn;
  logic [AW-1:0] WrAddr;
  logic [3:0]    WrData;
  logic [ND-1:0] BlankMask;
  logic          LzEnable;
  logic [3:0]    Nibble;
  logic [ND-1:0] DigitEn_n;
  logic          Blank;
  logic          FrameTick;
  scan_state_e   o_dbg_state;

  always #5 Clock = ~Clock;

  hex_scan_ctrl #(
    .NUM_DIGITS (ND),
    .DWELL_CYC  (DW),
    .GAP_CYC    (GP),
    .AW         (AW)
  ) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .WrEn        (WrEn),
    .WrAddr      (WrAddr),
    .WrData      (WrData),
    .BlankMask   (BlankMask),
    .LzEnable    (LzEnable),
    .Nibble      (Nibble),
    .DigitEn_n   (DigitEn_n),
    .Blank       (Blank),
    .FrameTick   (FrameTick),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [EW-1:0] exp_q[$];

  int            k;            // edges since reset release
  logic [3:0]    m_dig [ND];
  logic [3:0]    exp_nib;
  logic [ND-1:0] exp_en;
  logic          exp_blank;
  logic          exp_frame;
  logic          exp_show;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h k=%0d t=%0t", tag, got, exp, k, $time);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
    exp_nib   = 4'h0;
    exp_en    = '1;
    exp_blank = 1'b1;
    exp_frame = 1'b0;
    exp_show  = 1'b0;
    exp_q.delete();
  endtask

  // Whole display value as a number; digit i is a leading zero when
  // nothing at or above it is non-zero.
  function automatic logic is_suppressed(input int i, input logic lz);
    logic [4*ND-1:0] v;
    for (int j = 0; j < ND; j++) v[4*j +: 4] = m_dig[j];
    return lz && (i > 0) && ((v >> (4 * i)) == 0);
  endfunction

  task automatic model_edge();
    int off;
    int slot;
    logic lit;
    k++;
    if (WrEn && (int'(WrAddr) < ND)) m_dig[WrAddr] = WrData;
    off       = k % SLOT;
    exp_frame = 1'b0;
    if (off == GP) begin
      slot      = (k / SLOT) % ND;
      lit       = !BlankMask[slot] && !is_suppressed(slot, LzEnable);
      exp_nib   = m_dig[slot];
      exp_en    = '1;
      if (lit) exp_en[slot] = 1'b0;
      exp_blank = !lit;
      exp_show  = 1'b1;
    end else if (off == 0) begin
      exp_en    = '1;
      exp_blank = 1'b1;
      exp_show  = 1'b0;
      exp_frame = ((k % FRAME) == 0);
    end
    exp_q.push_back({exp_nib, exp_en, exp_blank, exp_frame, exp_show});
  endtask

  task automatic compare_front();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("nibble",    32'(Nibble),      32'(e[EW-1 -: 4]));
      check("digit_en",  32'(DigitEn_n),   32'(e[ND+2 -: ND]));
      check("blank",     32'(Blank),       32'(e[2]));
      check("frame",     32'(FrameTick),   32'(e[1]));
      check("state",     32'(o_dbg_state), 32'(e[0]));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_nibble"}, 32'(Nibble),      32'h0);
    check({tag, "_en"},     32'(DigitEn_n),   32'hF);
    check({tag, "_blank"},  32'(Blank),       32'h1);
    check({tag, "_frame"},  32'(FrameTick),   32'h0);
    check({tag, "_state"},  32'(o_dbg_state), 32'(ST_GAP));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: inputs already set; model the edge, then check at negedge.
  task automatic step();
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
    compare_front();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_digit(input int addr, input logic [3:0] data);
    WrEn   = 1'b1;
    WrAddr = AW'(addr);
    WrData = data;
    step();
    WrEn   = 1'b0;
  endtask

  // Step until the next edge lands on frame position 'target'.
  task automatic advance_to(input int target);
    for (int i = 0; i < FRAME; i++) begin
      if (((k + 1) % FRAME) == target) break;
      step();
    end
  endtask

  task automatic release_reset();
    @(negedge Clock);
    Resetn = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Resetn    = 1'b0;
    WrEn      = 1'b0;
    WrAddr    = '0;
    WrData    = 4'h0;
    BlankMask = '0;
    LzEnable  = 1'b0;
    model_reset();

    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_reset_values("rst");
    release_reset();

    // Idle scan with all digits zero.
    run(FRAME + 6);

    // Digits 3..0 = A,5,0,F.
    write_digit(3, 4'hA);
    write_digit(2, 4'h5);
    write_digit(1, 4'h0);
    write_digit(0, 4'hF);
    run(FRAME + 4);

    // Leading-zero suppression: 0,0,7,0 then all zero.
    LzEnable = 1'b1;
    write_digit(3, 4'h0);
    write_digit(2, 4'h0);
    write_digit(1, 4'h7);
    write_digit(0, 4'h0);
    run(FRAME + 2);
    write_digit(1, 4'h0);
    run(FRAME + 2);
    LzEnable = 1'b0;

    // BlankMask on digit 2 with digits 1,2,3,4.
    BlankMask = 4'b0100;
    write_digit(3, 4'h1);
    write_digit(2, 4'h2);
    write_digit(1, 4'h3);
    write_digit(0, 4'h4);
    run(FRAME + 2);
    BlankMask = '0;

    // Mid-slot write to digit 1 must not tear; entry-edge write forwards.
    write_digit(1, 4'h2);
    advance_to(GP + SLOT + 2);
    write_digit(1, 4'h9);
    run(FRAME);
    advance_to(GP + SLOT);
    write_digit(1, 4'hC);
    run(SLOT);

    // Randomized writes, masks and suppression.
    for (int i = 0; i < 300; i++) begin
      WrEn      = ($urandom_range(0, 2) == 0);
      WrAddr    = AW'($urandom_range(0, ND - 1));
      WrData    = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      BlankMask = ($urandom_range(0, 3) == 0) ? ND'($urandom_range(0, 15)) : '0;
      LzEnable  = 1'($urandom_range(0, 1));
      step();
    end
    WrEn      = 1'b0;
    BlankMask = '0;
    LzEnable  = 1'b0;
    write_digit(0, 4'h6);
    write_digit(2, 4'h8);

    // Asynchronous reset in the middle of digit 2's SHOW slot.
    advance_to(2 * SLOT + GP + 1);
    step();
    check("pre_rst_show", 32'(o_dbg_state), 32'(ST_SHOW));
    #2;
    Resetn = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge Clock);
    check_reset_values("hold_rst");
    release_reset();
    run(FRAME + 6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time limit in case the stimulus ever stalls.
  initial begin
    #500000;
    n_errors++;
    $display("FAIL timeout t=%0t", $time);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
